// File: rtl/piso_tx_if.sv
// ---------------------------------------------------------------------------
// piso_tx_if
//   Bundles the parallel-word handshake and the serial output side of the
//   piso_tx transmitter.
//
//   Handshake: a word transfers on a rising clk edge where in_valid and
//   in_ready are both high. The producer holds in_data stable while in_valid
//   is high. in_ready is a function of transmitter state only; it never
//   depends on in_valid in the same cycle.
//
//   Signals
//     in_data     WIDTH  parallel word, producer -> transmitter
//     in_valid    1      in_data is valid, producer -> transmitter
//     in_ready    1      transmitter takes a word on this edge
//     sout        1      serial data bit (registered)
//     sout_valid  1      sout carries a data bit this cycle
//     sout_first  1      first bit of a word
//     sout_last   1      last bit of a word
//     busy        1      a word is in flight (same as sout_valid)
//
//   Modports
//     master  producer / observer side (drives in_data, in_valid)
//     slave   transmitter side (piso_tx)
// ---------------------------------------------------------------------------
interface piso_tx_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             sout;
    logic             sout_valid;
    logic             sout_first;
    logic             sout_last;
    logic             busy;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  sout,
        input  sout_valid,
        input  sout_first,
        input  sout_last,
        input  busy
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output sout,
        output sout_valid,
        output sout_first,
        output sout_last,
        output busy
    );
endinterface

// File: rtl/piso_tx.sv
// ---------------------------------------------------------------------------
// piso_tx
//   Parallel-in serial-out transmitter. Takes a WIDTH-bit word over a
//   valid/ready handshake and sends it one bit per clk on sout, LSB-first
//   by default. The first bit appears in the cycle after the accept edge.
//   A new word may be accepted while the last bit of the current word is on
//   sout, so back-to-back words go out with no idle cycle between them.
//
//   Ports
//     clk          in   rising-edge clock
//     rst          in   synchronous, active-high reset (priority over all)
//     bus          slave modport of piso_tx_if (handshake + serial output)
//     dbg_state_o  out  current FSM state (0 = IDLE, 1 = SHIFT)
//
//   Parameters
//     WIDTH       word width, 2..32
//     LSB_FIRST   1: in_data[0] first; 0: in_data[WIDTH-1] first
//     IDLE_LEVEL  level driven on sout when no bit is being sent
// ---------------------------------------------------------------------------
module piso_tx #(
    parameter int WIDTH      = 4,
    parameter bit LSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    piso_tx_if.slave     bus,
    output logic         dbg_state_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("piso_tx: WIDTH must be in 2..32");
    end

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             sout_q,  sout_d;

    logic             last_bit;
    logic             ready;
    logic             accept;

    // The shift register only holds the bits still to be sent: the bit on
    // sout has already been moved into sout_q, so loading and shifting both
    // drop the outgoing bit.
    function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v);
        if (LSB_FIRST) begin
            return {1'b0, v[WIDTH-1:1]};
        end
        return {v[WIDTH-2:0], 1'b0};
    endfunction

    function automatic logic head_bit(input logic [WIDTH-1:0] v);
        if (LSB_FIRST) begin
            return v[0];
        end
        return v[WIDTH-1];
    endfunction

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        sout_d   = sout_q;

        last_bit = (state_q == S_SHIFT) && (cnt_q == CNT_LAST);
        ready    = (state_q == S_IDLE) || last_bit;
        accept   = bus.in_valid && ready;

        if (accept) begin
            // Covers both a start from IDLE and a reload on the last bit.
            state_d = S_SHIFT;
            cnt_d   = '0;
            sout_d  = head_bit(bus.in_data);
            shreg_d = shift_out(bus.in_data);
        end else if (last_bit) begin
            state_d = S_IDLE;
            sout_d  = IDLE_LEVEL;
        end else if (state_q == S_SHIFT) begin
            cnt_d   = cnt_q + CW'(1);
            sout_d  = head_bit(shreg_q);
            shreg_d = shift_out(shreg_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            sout_q  <= IDLE_LEVEL;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            sout_q  <= sout_d;
        end
    end

    assign bus.in_ready   = ready;
    assign bus.sout       = sout_q;
    assign bus.sout_valid = (state_q == S_SHIFT);
    assign bus.sout_first = (state_q == S_SHIFT) && (cnt_q == '0);
    assign bus.sout_last  = last_bit;
    assign bus.busy       = (state_q == S_SHIFT);
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_piso_tx.sv
// ---------------------------------------------------------------------------
// tb_piso_tx
//   Bench for piso_tx. dut4 (WIDTH=4, LSB-first, idle 0) is checked every
//   cycle against a queue model of the serial stream plus directed literal
//   cases; dut8 (WIDTH=8, MSB-first, idle 1) gets a directed case.
// ---------------------------------------------------------------------------
module tb_piso_tx;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    piso_tx_if #(.WIDTH(4)) bus4 ();
    piso_tx_if #(.WIDTH(8)) bus8 ();
    logic dbg4, dbg8;

    piso_tx #(.WIDTH(4), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4.slave), .dbg_state_o(dbg4)
    );

    piso_tx #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8.slave), .dbg_state_o(dbg8)
    );

    // Companion 4-bit SIPO receiver: d -> q[MSB], shifting right every clk.
    logic [3:0] sipo_q;
    always @(posedge clk) sipo_q <= {bus4.sout, sipo_q[3:1]};

    // ---------------- counters ----------------
    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // exp_q holds the serial symbols still to appear on sout, front = the
    // symbol shown in the current cycle. Entry = {bit, first, last}.
    logic [2:0] exp_q[$];

    always @(posedge clk) begin
        bit rdy;
        logic [3:0] w;
        if (rst) begin
            exp_q.delete();
        end else begin
            // Ready when nothing is showing, or the showing bit is the last one.
            rdy = (exp_q.size() <= 1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (bus4.in_valid && rdy) begin
                w = bus4.in_data;
                for (int i = 0; i < 4; i++)
                    exp_q.push_back({w[i], i == 0, i == 3});
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [2:0] e;
        if (chk_en) begin
            e = (exp_q.size() > 0) ? exp_q[0] : 3'b000;
            check("in_ready",   bus4.in_ready,   exp_q.size() <= 1);
            check("sout_valid", bus4.sout_valid, exp_q.size() > 0);
            check("busy",       bus4.busy,       exp_q.size() > 0);
            check("sout",       bus4.sout,       e[2]);
            check("sout_first", bus4.sout_first, e[1]);
            check("sout_last",  bus4.sout_last,  e[0]);
        end
    end

    // ---------------- driver tasks ----------------
    // Each capture starts at the negedge of bit 0 and ends at the negedge
    // after the last captured cycle.
    task automatic capture4(output logic [3:0] d, output logic [3:0] f, output logic [3:0] l);
        for (int i = 0; i < 4; i++) begin
            d[i] = bus4.sout;
            f[i] = bus4.sout_first;
            l[i] = bus4.sout_last;
            @(negedge clk);
        end
    endtask

    task automatic send4(input logic [3:0] w);
        bus4.in_valid = 1'b1;
        bus4.in_data  = w;
        @(negedge clk);
        bus4.in_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] d4, f4, l4;
        logic [7:0] s8, r8, v8, f8, l8;

        bus4.in_valid = 1'b0;
        bus4.in_data  = '0;
        bus8.in_valid = 1'b0;
        bus8.in_data  = '0;

        repeat (3) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Reset state
        check("rst_sout",   bus4.sout,       1'b0);
        check("rst_valid",  bus4.sout_valid, 1'b0);
        check("rst_ready",  bus4.in_ready,   1'b1);
        check("rst_sout8",  bus8.sout,       1'b1);

        // Single word 4'b1011, plus SIPO loopback
        send4(4'b1011);
        capture4(d4, f4, l4);
        check("w1_bits",  d4, 4'b1011);
        check("w1_first", f4, 4'b0001);
        check("w1_last",  l4, 4'b1000);
        check("w1_idle_sout",  bus4.sout,       1'b0);
        check("w1_idle_valid", bus4.sout_valid, 1'b0);
        check("sipo_q",        sipo_q,          4'hB);

        // in_valid held high: 4'hB then 4'h6, in_data wiggles while not ready
        bus4.in_valid = 1'b1;
        bus4.in_data  = 4'hB;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            s8[i] = bus4.sout;
            r8[i] = bus4.in_ready;
            v8[i] = bus4.sout_valid;
            if (i == 0 || i == 1) bus4.in_data = 4'($urandom);
            if (i == 2) bus4.in_data = 4'h6;
            if (i == 4) bus4.in_valid = 1'b0;
            @(negedge clk);
        end
        check("b2b_bits",  s8, 8'h6B);
        check("b2b_ready", r8, 8'b1000_1000);
        check("b2b_valid", v8, 8'hFF);
        check("b2b_idle",  bus4.sout_valid, 1'b0);

        // Reset on the edge ending bit 2 of 4'hF
        send4(4'hF);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_sout",  bus4.sout,       1'b0);
        check("abort_valid", bus4.sout_valid, 1'b0);
        check("abort_ready", bus4.in_ready,   1'b1);
        send4(4'h9);
        capture4(d4, f4, l4);
        check("after_abort_bits",  d4, 4'h9);
        check("after_abort_first", f4, 4'b0001);

        // WIDTH=8, MSB-first, idle level 1: send 8'hA5
        bus8.in_valid = 1'b1;
        bus8.in_data  = 8'hA5;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s8[7-i] = bus8.sout;
            f8[i]   = bus8.sout_first;
            l8[i]   = bus8.sout_last;
            @(negedge clk);
        end
        check("w8_bits",  s8, 8'hA5);
        check("w8_first", f8, 8'h01);
        check("w8_last",  l8, 8'h80);
        check("w8_idle_sout",  bus8.sout,       1'b1);
        check("w8_idle_valid", bus8.sout_valid, 1'b0);

        // Randomised traffic with occasional resets; continuous-valid bursts
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 149) == 0);
            bus4.in_data  = 4'($urandom);
            if (i % 500 < 60) bus4.in_valid = 1'b1;
            else              bus4.in_valid = ($urandom_range(0, 9) < 6);
            @(negedge clk);
        end
        rst           = 1'b0;
        bus4.in_valid = 1'b0;
        repeat (8) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
